// File: rtl/ifu_prefetch_pkg.sv
// Shared fetch-unit defaults and prefetch state encoding.
package ifu_prefetch_pkg;
  localparam int          ADDR_LEN_D = 32;
  localparam int          ISA_LEN_D  = 32;
  localparam logic [31:0] NOP_INST_D = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_D = 32'h0000_0000;

  typedef enum logic {
    FETCH_S = 1'b0,
    DRAIN_S = 1'b1
  } pf_state_e;
endpackage

// File: rtl/ifu_pf_fifo.sv
// First-word-fall-through FIFO; push and pop in the same cycle keep the count.
module ifu_pf_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch: credit-limited in-order reads into a FIFO feeding a registered decode stage.
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int                  ADDR_LEN = ADDR_LEN_D,
  parameter int                  ISA_LEN  = ISA_LEN_D,
  parameter int                  DEPTH    = 4,
  parameter int                  MAX_OUT  = 2,
  parameter logic [ADDR_LEN-1:0] RESET_PC = ADDR_LEN'(RESET_PC_D),
  parameter logic [ISA_LEN-1:0]  NOP_INST = ISA_LEN'(NOP_INST_D)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [ADDR_LEN-1:0] jmp_addr_i,
  input  logic                stall,
  output logic                rd_req_o,
  output logic [ADDR_LEN-1:0] rd_addr_o,
  input  logic                busy_,
  input  logic                rd_valid_i,
  input  logic [ISA_LEN-1:0]  rd_data_i,
  output logic [ISA_LEN-1:0]  inst_o,
  output logic [ADDR_LEN-1:0] pc_o,
  output logic                valid_o,
  output logic                wait_
);
  localparam int             CW        = $clog2(DEPTH + 1);
  localparam int             EW        = ADDR_LEN + ISA_LEN;
  localparam logic [CW:0]    DEPTH_C   = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0]  MAX_OUT_C = CW'(MAX_OUT);

  pf_state_e           state, state_nxt;
  logic [ADDR_LEN-1:0] fetch_pc, rsp_pc;
  logic [CW-1:0]       out_cnt, discard_cnt, discard_nxt, out_after_rsp, fifo_cnt;
  logic [CW:0]         credit_used;
  logic                accept, drop, push, pop, fifo_empty;
  logic [EW-1:0]       fifo_head;

  // Outstanding reads (including ones about to be discarded) consume FIFO credit,
  // so a kept response always has a free slot.
  assign credit_used = {1'b0, fifo_cnt} + {1'b0, out_cnt};
  assign rd_req_o    = !rst && !flush && (credit_used < DEPTH_C) && (out_cnt < MAX_OUT_C);
  assign rd_addr_o   = fetch_pc;
  assign accept      = rd_req_o && busy_;

  // Responses are in order, so the oldest discard_cnt responses are the stale ones.
  assign drop   = rd_valid_i && (state == DRAIN_S);
  assign push   = rd_valid_i && (state == FETCH_S) && !flush;
  assign pop    = !flush && !fifo_empty && (!stall || !valid_o);
  assign rsp_pc = fifo_head[EW-1:ISA_LEN];
  assign wait_  = !rst && (!fifo_empty || push || flush);

  always_comb begin
    out_after_rsp = out_cnt - CW'(rd_valid_i);
    discard_nxt   = discard_cnt;
    if (flush)     discard_nxt = out_after_rsp;
    else if (drop) discard_nxt = discard_cnt - CW'(1);
    state_nxt = (discard_nxt != '0) ? DRAIN_S : FETCH_S;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH_S;
      fetch_pc    <= RESET_PC;
      out_cnt     <= '0;
      discard_cnt <= '0;
      inst_o      <= NOP_INST;
      pc_o        <= '0;
      valid_o     <= 1'b0;
    end else begin
      state       <= state_nxt;
      discard_cnt <= discard_nxt;
      out_cnt     <= out_after_rsp + CW'(accept);
      if (flush)       fetch_pc <= jmp_addr_i;
      else if (accept) fetch_pc <= fetch_pc + ADDR_LEN'(4);
      if (flush) begin
        valid_o <= 1'b0;
        inst_o  <= NOP_INST;
      end else if (!stall || !valid_o) begin
        if (!fifo_empty) begin
          pc_o    <= rsp_pc;
          inst_o  <= fifo_head[ISA_LEN-1:0];
          valid_o <= 1'b1;
        end else begin
          inst_o  <= NOP_INST;
          valid_o <= 1'b0;
        end
      end
    end
  end

  ifu_pf_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push),
    .din   ({fetch_pc_of_rsp(), rd_data_i}),
    .pop   (pop),
    .head  (fifo_head),
    .count (fifo_cnt),
    .empty (fifo_empty)
  );

  // PC of the response being pushed: the oldest kept request address.
  logic [ADDR_LEN-1:0] rsp_addr_q [DEPTH];
  logic [$clog2(DEPTH)-1:0] ra_wr, ra_rd;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ra_wr <= '0;
      ra_rd <= '0;
    end else begin
      if (accept) ra_wr <= ra_wr + 1'b1;
      if (push)   ra_rd <= ra_rd + 1'b1;
    end
  end

  // Stale requests are never stored here: the tracker restarts at the redirect.
  always_ff @(posedge clk) begin
    if (accept) rsp_addr_q[ra_wr] <= fetch_pc;
  end

  function automatic logic [ADDR_LEN-1:0] fetch_pc_of_rsp();
    return rsp_addr_q[ra_rd];
  endfunction

  assert property (@(posedge clk) disable iff (rst) rd_valid_i |-> (out_cnt != '0));
endmodule
